riscv_mc_control: RTL and testbench

RISCV_MC_CONTROL -- requirements
Module: riscv_mc_control

---
 rtl/riscv_mc_pkg.sv | 119 +++++++++++
 rtl/riscv_alu_decoder.sv | 25 ++
 rtl/riscv_mc_control.sv | 163 ++++++++++++++++
 tb/tb_riscv_mc_control.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_mc_pkg.sv
// Shared types and encodings for the multicycle RISC-V control unit.
// The state-to-control mapping lives here so the FSM can register it against the next state.
package riscv_mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECUTER,
    S_EXECUTEI,
    S_ALUWB,
    S_JAL,
    S_BEQ,
    S_TRAP
  } state_t;

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_RDATA  = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  // Enables that depend on a live input are stored as qualifiers and gated at the output.
  typedef struct packed {
    logic       pc_uncond;
    logic       pc_on_ready;
    logic       pc_on_zero;
    logic       ir_on_ready;
    logic       mem_write;
    logic       reg_write;
    logic       adr_src;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_control;
  } ctrl_t;

  function automatic ctrl_t state_ctrl(input state_t s, input logic [2:0] alu_op);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.pc_on_ready = 1'b1;
        c.ir_on_ready = 1'b1;
        c.alu_src_b   = SRCB_FOUR;
        c.result_src  = RES_ALU;
      end
      S_DECODE: begin
        c.alu_src_a = SRCA_OLDPC;
        c.alu_src_b = SRCB_IMM;
      end
      S_MEMADR: begin
        c.alu_src_a = SRCA_RS1;
        c.alu_src_b = SRCB_IMM;
      end
      S_MEMREAD: c.adr_src = 1'b1;
      S_MEMWB: begin
        c.result_src = RES_RDATA;
        c.reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        c.adr_src   = 1'b1;
        c.mem_write = 1'b1;
      end
      S_EXECUTER: begin
        c.alu_src_a   = SRCA_RS1;
        c.alu_src_b   = SRCB_RS2;
        c.alu_control = alu_op;
      end
      S_EXECUTEI: begin
        c.alu_src_a   = SRCA_RS1;
        c.alu_src_b   = SRCB_IMM;
        c.alu_control = alu_op;
      end
      S_ALUWB: c.reg_write = 1'b1;
      S_JAL: begin
        c.alu_src_a = SRCA_OLDPC;
        c.alu_src_b = SRCB_FOUR;
        c.pc_uncond = 1'b1;
      end
      S_BEQ: begin
        c.alu_src_a   = SRCA_RS1;
        c.alu_src_b   = SRCB_RS2;
        c.alu_control = ALU_SUB;
        c.pc_on_zero  = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/riscv_alu_decoder.sv
// Combinational ALU operation decode from funct3/funct7 for R-type and I-type ALU instructions.
module riscv_alu_decoder
  import riscv_mc_pkg::*;
(
  input  logic [6:0] i_op,
  input  logic [2:0] i_funct3,
  input  logic       i_funct7,
  output logic [2:0] o_alu_control,
  output logic       o_bad_funct3
);

  always_comb begin
    o_alu_control = ALU_ADD;
    o_bad_funct3  = 1'b0;
    case (i_funct3)
      // Bit 30 only selects sub for register-register forms; addi ignores it.
      3'b000:  o_alu_control = (i_op[5] & i_funct7) ? ALU_SUB : ALU_ADD;
      3'b010:  o_alu_control = ALU_SLT;
      3'b110:  o_alu_control = ALU_OR;
      3'b111:  o_alu_control = ALU_AND;
      default: o_bad_funct3  = 1'b1;
    endcase
  end

endmodule

// File: rtl/riscv_mc_control.sv
// Multicycle RISC-V control FSM with registered Moore controls and sticky fault flags.
// Define RISCV_MC_MEM_WAIT_EN to honour mem_ready and trap on MEM_TIMEOUT wait cycles.
module riscv_mc_control
  import riscv_mc_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       a_rst,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       adr_src,
  output logic       ir_write,
  output logic       mem_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] imm_src,
  output logic [2:0] alu_control,
  output logic       illegal,
  output logic       bus_err
);

  state_t     r_state;
  state_t     w_next;
  ctrl_t      r_ctrl;
  ctrl_t      w_next_ctrl;
  logic       r_illegal;
  logic       r_bus_err;
  logic       w_set_illegal;
  logic       w_set_bus_err;
  logic       w_ready;
  logic       w_timeout;
  logic [2:0] w_alu_op;
  logic       w_bad_funct3;

  riscv_alu_decoder u_alu_decoder (
    .i_op          (op),
    .i_funct3      (funct3),
    .i_funct7      (funct7),
    .o_alu_control (w_alu_op),
    .o_bad_funct3  (w_bad_funct3)
  );

`ifdef RISCV_MC_MEM_WAIT_EN
  logic [7:0] r_wait_cnt;
  logic       w_waiting;

  assign w_ready   = mem_ready;
  assign w_waiting = !mem_ready &&
                     (r_state == S_FETCH || r_state == S_MEMREAD || r_state == S_MEMWRITE);
  // The wait that would bring the count to MEM_TIMEOUT is the one that traps.
  assign w_timeout = w_waiting && (r_wait_cnt == 8'(MEM_TIMEOUT - 1));

  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst)
      r_wait_cnt <= '0;
    else if (w_waiting && !w_timeout)
      r_wait_cnt <= r_wait_cnt + 8'd1;
    else
      r_wait_cnt <= '0;
  end
`else
  logic [8:0] w_unused;

  assign w_ready   = 1'b1;
  assign w_timeout = 1'b0;
  assign w_unused  = {mem_ready, 8'(MEM_TIMEOUT)};
`endif

  always_comb begin
    w_next        = r_state;
    w_set_illegal = 1'b0;
    w_set_bus_err = 1'b0;
    case (r_state)
      S_FETCH: begin
        if (w_timeout) begin
          w_next        = S_TRAP;
          w_set_bus_err = 1'b1;
        end else if (w_ready) begin
          w_next = S_DECODE;
        end
      end
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_RTYPE:     w_next = w_bad_funct3 ? S_TRAP : S_EXECUTER;
          OP_ITYPE:     w_next = w_bad_funct3 ? S_TRAP : S_EXECUTEI;
          OP_JAL:       w_next = S_JAL;
          OP_BEQ:       w_next = S_BEQ;
          default:      w_next = S_TRAP;
        endcase
        w_set_illegal = (w_next == S_TRAP);
      end
      S_MEMADR: w_next = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD: begin
        if (w_timeout) begin
          w_next        = S_TRAP;
          w_set_bus_err = 1'b1;
        end else if (w_ready) begin
          w_next = S_MEMWB;
        end
      end
      S_MEMWRITE: begin
        if (w_timeout) begin
          w_next        = S_TRAP;
          w_set_bus_err = 1'b1;
        end else if (w_ready) begin
          w_next = S_FETCH;
        end
      end
      S_MEMWB, S_ALUWB, S_BEQ: w_next = S_FETCH;
      S_EXECUTER, S_EXECUTEI, S_JAL: w_next = S_ALUWB;
      default: w_next = S_TRAP;
    endcase
  end

  assign w_next_ctrl = state_ctrl(w_next, w_alu_op);

  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      r_state   <= S_FETCH;
      r_ctrl    <= state_ctrl(S_FETCH, ALU_ADD);
      r_illegal <= 1'b0;
      r_bus_err <= 1'b0;
    end else begin
      r_state <= w_next;
      r_ctrl  <= w_next_ctrl;
      if (w_set_illegal) r_illegal <= 1'b1;
      if (w_set_bus_err) r_bus_err <= 1'b1;
    end
  end

  // FETCH controls are live during reset, so the input-qualified enables are masked by it.
  assign pc_write    = !a_rst && (r_ctrl.pc_uncond ||
                                  (r_ctrl.pc_on_ready && w_ready) ||
                                  (r_ctrl.pc_on_zero && zero));
  assign ir_write    = !a_rst && r_ctrl.ir_on_ready && w_ready;
  assign mem_write   = r_ctrl.mem_write;
  assign reg_write   = r_ctrl.reg_write;
  assign adr_src     = r_ctrl.adr_src;
  assign result_src  = r_ctrl.result_src;
  assign alu_src_a   = r_ctrl.alu_src_a;
  assign alu_src_b   = r_ctrl.alu_src_b;
  assign alu_control = r_ctrl.alu_control;
  assign illegal     = r_illegal;
  assign bus_err     = r_bus_err;

  always_comb begin
    case (op)
      OP_SW:   imm_src = IMM_S;
      OP_BEQ:  imm_src = IMM_B;
      OP_JAL:  imm_src = IMM_J;
      default: imm_src = IMM_I;
    endcase
  end

endmodule

// File: tb/tb_riscv_mc_control.sv
// Directed scoreboard bench for riscv_mc_control; adapts expectations to RISCV_MC_MEM_WAIT_EN.
module tb_riscv_mc_control;

`ifdef RISCV_MC_MEM_WAIT_EN
  localparam bit WAIT_EN = 1'b1;
`else
  localparam bit WAIT_EN = 1'b0;
`endif
  localparam int TO      = 4;
  localparam int N_FWAIT = WAIT_EN ? 2 : 0;
  localparam int N_LWAIT = WAIT_EN ? 3 : 0;
  localparam int N_SWAIT = WAIT_EN ? TO : 1;

  localparam logic [6:0] OPC_R   = 7'b0110011;
  localparam logic [6:0] OPC_I   = 7'b0010011;
  localparam logic [6:0] OPC_LW  = 7'b0000011;
  localparam logic [6:0] OPC_SW  = 7'b0100011;
  localparam logic [6:0] OPC_JAL = 7'b1101111;
  localparam logic [6:0] OPC_BEQ = 7'b1100011;

  logic       clk = 1'b0;
  logic       a_rst;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7;
  logic       zero;
  logic       mem_ready;
  logic       pc_write, adr_src, ir_write, mem_write, reg_write;
  logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
  logic [2:0] alu_control;
  logic       illegal, bus_err;

  always #5 clk = ~clk;

  riscv_mc_control #(.MEM_TIMEOUT(TO)) dut (
    .clk(clk), .a_rst(a_rst), .op(op), .funct3(funct3), .funct7(funct7),
    .zero(zero), .mem_ready(mem_ready), .pc_write(pc_write), .adr_src(adr_src),
    .ir_write(ir_write), .mem_write(mem_write), .reg_write(reg_write),
    .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .imm_src(imm_src), .alu_control(alu_control), .illegal(illegal), .bus_err(bus_err)
  );

  typedef enum {T_FETCH, T_DECODE, T_MEMADR, T_MEMREAD, T_MEMWB, T_MEMWRITE,
                T_EXECR, T_EXECI, T_ALUWB, T_JAL, T_BEQ, T_TRAP, T_RST} tst_t;

  logic [17:0] exp_q[$];
  string       tag_q[$];
  int          errors = 0;
  int          checks = 0;
  logic        rst_v = 1'b1;
  logic        m_ill = 1'b0;
  logic        m_be  = 1'b0;
  logic [6:0]  cur_op = '0;
  logic [2:0]  cur_f3 = '0;
  logic        cur_f7 = 1'b0;

  logic [6:0] t_op  [7] = '{OPC_R, OPC_R, OPC_R, OPC_R, OPC_I, OPC_I, OPC_I};
  logic [2:0] t_f3  [7] = '{3'b000, 3'b000, 3'b111, 3'b110, 3'b010, 3'b000, 3'b111};
  logic       t_f7  [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  logic [2:0] t_alu [7] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b101, 3'b000, 3'b010};

  // Expected output vector for a state, from the control table of the instruction set spec.
  function automatic logic [17:0] model(input tst_t s, input logic [6:0] o, input logic rdy,
                                        input logic z, input logic [2:0] aluc,
                                        input logic ill, input logic be);
    logic pcw, adr, irw, mw, rw, r;
    logic [1:0] rs, a, b, imm;
    logic [2:0] alu;
    r = WAIT_EN ? rdy : 1'b1;
    pcw = 0; adr = 0; irw = 0; mw = 0; rw = 0;
    rs = 2'b00; a = 2'b00; b = 2'b00; alu = 3'b000;
    imm = (o == OPC_SW) ? 2'b01 : (o == OPC_BEQ) ? 2'b10 : (o == OPC_JAL) ? 2'b11 : 2'b00;
    case (s)
      T_FETCH:    begin pcw = r; irw = r; b = 2'b10; rs = 2'b10; end
      T_RST:      begin b = 2'b10; rs = 2'b10; end
      T_DECODE:   begin a = 2'b01; b = 2'b01; end
      T_MEMADR:   begin a = 2'b10; b = 2'b01; end
      T_MEMREAD:  adr = 1'b1;
      T_MEMWB:    begin rs = 2'b01; rw = 1'b1; end
      T_MEMWRITE: begin adr = 1'b1; mw = 1'b1; end
      T_EXECR:    begin a = 2'b10; alu = aluc; end
      T_EXECI:    begin a = 2'b10; b = 2'b01; alu = aluc; end
      T_ALUWB:    rw = 1'b1;
      T_JAL:      begin a = 2'b01; b = 2'b10; pcw = 1'b1; end
      T_BEQ:      begin a = 2'b10; alu = 3'b001; pcw = z; end
      default:    ;
    endcase
    return {pcw, adr, irw, mw, rw, rs, a, b, imm, alu, ill, be};
  endfunction

  task automatic instr(input logic [6:0] o, input logic [2:0] f3, input logic f7);
    cur_op = o; cur_f3 = f3; cur_f7 = f7;
  endtask

  task automatic step(input string tag, input tst_t s, input logic rdy = 1'b1,
                      input logic z = 1'b0, input logic [2:0] aluc = 3'b000);
    logic [17:0] got, e;
    string t;
    @(negedge clk);
    a_rst = rst_v; op = cur_op; funct3 = cur_f3; funct7 = cur_f7;
    zero = z; mem_ready = rdy;
    exp_q.push_back(model(s, cur_op, rdy, z, aluc, m_ill, m_be));
    tag_q.push_back(tag);
    #1;
    got = {pc_write, adr_src, ir_write, mem_write, reg_write, result_src,
           alu_src_a, alu_src_b, imm_src, alu_control, illegal, bus_err};
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    checks++;
    assert (got === e) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", t, got, e);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    a_rst = 1'b1; op = '0; funct3 = '0; funct7 = 1'b0; zero = 1'b0; mem_ready = 1'b1;
    instr(OPC_R, 3'b000, 1'b0);
    step("reset_hold", T_RST);
    step("reset_hold_rdy", T_RST, 1'b1);
    rst_v = 1'b0;

    // add x3,x1,x2 (fetch stalls only matter when waits are honoured)
    for (int i = 0; i < N_FWAIT; i++) step("fetch_stall", T_FETCH, 1'b0);
    step("add_fetch", T_FETCH);
    step("add_decode", T_DECODE);
    step("add_exec", T_EXECR, 1'b1, 1'b0, 3'b000);
    step("add_wb", T_ALUWB);

    for (int i = 0; i < 7; i++) begin
      instr(t_op[i], t_f3[i], t_f7[i]);
      step("alu_fetch", T_FETCH);
      step("alu_decode", T_DECODE);
      step("alu_exec", (t_op[i] == OPC_R) ? T_EXECR : T_EXECI, 1'b1, 1'b0, t_alu[i]);
      step("alu_wb", T_ALUWB);
    end

    // lw with a stalled read
    instr(OPC_LW, 3'b010, 1'b0);
    step("lw_fetch", T_FETCH);
    step("lw_decode", T_DECODE);
    step("lw_memadr", T_MEMADR);
    for (int i = 0; i < N_LWAIT; i++) step("lw_read_wait", T_MEMREAD, 1'b0);
    step("lw_read", T_MEMREAD);
    step("lw_wb", T_MEMWB);

    instr(OPC_SW, 3'b010, 1'b0);
    step("sw_fetch", T_FETCH);
    step("sw_decode", T_DECODE);
    step("sw_memadr", T_MEMADR);
    step("sw_write", T_MEMWRITE);

    instr(OPC_JAL, 3'b000, 1'b0);
    step("jal_fetch", T_FETCH);
    step("jal_decode", T_DECODE);
    step("jal_exec", T_JAL);
    step("jal_wb", T_ALUWB);

    instr(OPC_BEQ, 3'b000, 1'b0);
    step("beq1_fetch", T_FETCH);
    step("beq1_decode", T_DECODE);
    step("beq_taken", T_BEQ, 1'b1, 1'b1);
    step("beq0_fetch", T_FETCH);
    step("beq0_decode", T_DECODE);
    step("beq_not_taken", T_BEQ, 1'b1, 1'b0);

    // Reset mid-instruction, landing on the writeback cycle
    instr(OPC_R, 3'b000, 1'b0);
    step("abort_fetch", T_FETCH);
    step("abort_decode", T_DECODE);
    step("abort_exec", T_EXECR);
    rst_v = 1'b1;
    step("abort_reset", T_RST);
    rst_v = 1'b0;
    step("abort_refetch", T_FETCH);
    step("abort_redecode", T_DECODE);
    step("abort_reexec", T_EXECR);
    step("abort_rewb", T_ALUWB);

    // Unsupported funct3 on an R-type
    instr(OPC_R, 3'b001, 1'b0);
    step("badf3_fetch", T_FETCH);
    step("badf3_decode", T_DECODE);
    m_ill = 1'b1;
    for (int i = 0; i < 3; i++) step("badf3_trap", T_TRAP);
    m_ill = 1'b0; rst_v = 1'b1;
    step("badf3_reset", T_RST);
    rst_v = 1'b0;

    // Opcode zero traps and stays trapped
    instr(7'b0000000, 3'b000, 1'b0);
    step("badop_fetch", T_FETCH);
    step("badop_decode", T_DECODE);
    m_ill = 1'b1;
    for (int i = 0; i < 10; i++) step("badop_trap", T_TRAP, 1'b1, 1'b1);
    m_ill = 1'b0; rst_v = 1'b1;
    step("badop_reset", T_RST);
    rst_v = 1'b0;
    step("badop_refetch", T_FETCH);

    // sw with mem_ready stuck low
    instr(OPC_SW, 3'b010, 1'b0);
    step("swto_decode", T_DECODE);
    step("swto_memadr", T_MEMADR);
    for (int i = 0; i < N_SWAIT; i++) step("swto_write", T_MEMWRITE, 1'b0);
    m_be = WAIT_EN;
    step("swto_after", WAIT_EN ? T_TRAP : T_FETCH, 1'b0);
    m_be = 1'b0; rst_v = 1'b1;
    step("swto_reset", T_RST);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
